// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: registered one-hot / priority bit-index encoder with a
// valid/ready handshake on both sides (latency 1, throughput 1 per cycle).
// PRIORITY=0 accepts only exactly-one-bit inputs. PRIORITY=1 reports the
// lowest set bit. Invalid inputs produce INVALID_CODE with out_err=1.
// Optional feature: define ONEHOT_ENCODER_ERRCNT_EN to add a saturating
// 16-bit error counter with ports err_clr / err_count.
module onehot_encoder_pipe #(
    parameter int                WIDTH        = 32,
    parameter int                OUT_W        = 5,
    parameter int                PRIORITY     = 0,
    parameter logic [OUT_W-1:0]  INVALID_CODE = '1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_code,
    output logic              out_err
`ifdef ONEHOT_ENCODER_ERRCNT_EN
    ,
    input  logic              err_clr,
    output logic [15:0]       err_count
`endif
);

    logic              valid_q, valid_d;
    logic [OUT_W-1:0]  code_q, code_d;
    logic              err_q, err_d;

    logic              accept;
    logic              any_set;
    logic              multi_set;
    logic              enc_ok;
    logic [OUT_W-1:0]  low_idx;

    // The output stage is free when empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Lowest set-bit index; scanning downward lets the lowest bit win.
    always_comb begin
        low_idx = '0;
        any_set = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                low_idx = OUT_W'(i);
                any_set = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_set = |(in_vec & (in_vec - WIDTH'(1)));
    assign enc_ok    = (PRIORITY != 0) ? any_set : (any_set && !multi_set);

    // Output register next state: load on accept, drop valid when drained.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            code_d  = enc_ok ? low_idx : INVALID_CODE;
            err_d   = !enc_ok;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register; reset discards any held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_err   = err_q;

`ifdef ONEHOT_ENCODER_ERRCNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count accepted invalid inputs, saturating; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (accept && !enc_ok && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: one strict and one priority instance share
// stimulus; expected {err, code} pairs are queued on acceptance and compared
// while the matching result is presented.
module tb_onehot_encoder_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_vec = '0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        s_ready, s_valid, s_err;
    logic [4:0]  s_code;
    logic        p_ready, p_valid, p_err;
    logic [4:0]  p_code;
    logic [15:0] s_cnt, p_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    logic [5:0]  sb_s[$];
    logic [5:0]  sb_p[$];
    logic [15:0] cnt_s = '0;
    logic [15:0] cnt_p = '0;

    typedef struct { bit v; logic [31:0] vec; bit ordy; } stim_t;

    always #5 clock = ~clock;

    onehot_encoder_pipe #(.WIDTH(32), .OUT_W(5), .PRIORITY(0)) u_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_ready),
        .in_vec(in_vec), .out_valid(s_valid), .out_ready(out_ready),
        .out_code(s_code), .out_err(s_err)
`ifdef ONEHOT_ENCODER_ERRCNT_EN
        , .err_clr(err_clr), .err_count(s_cnt)
`endif
    );

    onehot_encoder_pipe #(.WIDTH(32), .OUT_W(5), .PRIORITY(1)) u_p (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(p_ready),
        .in_vec(in_vec), .out_valid(p_valid), .out_ready(out_ready),
        .out_code(p_code), .out_err(p_err)
`ifdef ONEHOT_ENCODER_ERRCNT_EN
        , .err_clr(err_clr), .err_count(p_cnt)
`endif
    );

`ifndef ONEHOT_ENCODER_ERRCNT_EN
    assign s_cnt = '0;
    assign p_cnt = '0;
`endif

    // Reference encoding, returned as {err, code}.
    function automatic logic [5:0] exp_of(input logic [31:0] v, input bit prio);
        int lo;
        lo = 0;
        for (int i = 31; i >= 0; i--) if (v[i]) lo = i;
        if (v == 32'd0) return {1'b1, 5'd31};
        if (!prio && $countones(v) != 1) return {1'b1, 5'd31};
        return {1'b0, lo[4:0]};
    endfunction

    // Drive one cycle of stimulus and update the scoreboard for that edge.
    task automatic step(input bit v, input logic [31:0] vec, input bit ordy,
                        input bit rst, input bit clr);
        bit rdy;
        logic [5:0] es, ep;
        @(negedge clock);
        in_valid  = v;
        in_vec    = vec;
        out_ready = ordy;
        reset     = rst;
        err_clr   = clr;
        rdy = (sb_s.size() == 0) || ordy;
        if (rst) begin
            sb_s.delete();
            sb_p.delete();
            cnt_s = '0;
            cnt_p = '0;
        end else begin
            if (sb_s.size() != 0 && ordy) begin
                void'(sb_s.pop_front());
                void'(sb_p.pop_front());
            end
            es = exp_of(vec, 1'b0);
            ep = exp_of(vec, 1'b1);
            if (v && rdy) begin
                sb_s.push_back(es);
                sb_p.push_back(ep);
            end
            if (clr) cnt_s = '0;
            else if (v && rdy && es[5] && cnt_s != 16'hFFFF) cnt_s = cnt_s + 16'd1;
            if (clr) cnt_p = '0;
            else if (v && rdy && ep[5] && cnt_p != 16'hFFFF) cnt_p = cnt_p + 16'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({s_valid, s_code, s_err, s_ready, p_valid, p_code, p_err, p_ready} !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got s=%b/%0d/%b/%b p=%b/%0d/%b/%b want 0/0/0/1", s_valid, s_code, s_err, s_ready, p_valid, p_code, p_err, p_ready);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({s_valid, s_ready, p_valid, p_ready} !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_release: got valid/ready s=%b%b p=%b%b want 01", s_valid, s_ready, p_valid, p_ready);
        end
    endtask

    // Run a stimulus list, checking both instances after every edge.
    task automatic run_list(input string name, input stim_t lst[$]);
        foreach (lst[k]) begin
            step(lst[k].v, lst[k].vec, lst[k].ordy, 1'b0, 1'b0);
            n_cmp++;
            if ({s_valid, s_ready, p_valid, p_ready} !== {sb_s.size() != 0, sb_s.size() == 0 || out_ready, sb_p.size() != 0, sb_p.size() == 0 || out_ready}) begin
                n_fail++;
                $display("FAIL %s[%0d] valid/ready: got s=%b%b p=%b%b want s=%b%b", name, k, s_valid, s_ready, p_valid, p_ready, sb_s.size() != 0, sb_s.size() == 0 || out_ready);
            end
            if (sb_s.size() != 0) begin
                n_cmp++;
                if ({s_err, s_code} !== sb_s[0] || {p_err, p_code} !== sb_p[0]) begin
                    n_fail++;
                    $display("FAIL %s[%0d] code: vec=%h strict got %b/%0d want %b/%0d, prio got %b/%0d want %b/%0d", name, k, in_vec, s_err, s_code, sb_s[0][5], sb_s[0][4:0], p_err, p_code, sb_p[0][5], sb_p[0][4:0]);
                end
            end
        end
    endtask

    task automatic test_codes();
        stim_t l[$];
        l = '{'{1'b1, 32'h0000_0010, 1'b1}, '{1'b1, 32'h0000_0030, 1'b1},
              '{1'b1, 32'h0000_0000, 1'b1}, '{1'b1, 32'h0000_0001, 1'b1},
              '{1'b1, 32'h8000_0000, 1'b1}, '{1'b1, 32'h00F0_0000, 1'b1},
              '{1'b1, 32'hC000_0000, 1'b1}, '{1'b1, 32'h0001_0000, 1'b1},
              '{1'b1, 32'hFFFF_FFFF, 1'b1}, '{1'b0, 32'h0000_0004, 1'b1}};
        run_list("codes", l);
    endtask

    task automatic test_backpressure();
        stim_t l[$];
        l = '{'{1'b1, 32'h8000_0000, 1'b1}, '{1'b1, 32'h0000_0100, 1'b0},
              '{1'b1, 32'h0000_0200, 1'b0}, '{1'b1, 32'h0000_0003, 1'b0},
              '{1'b1, 32'h0000_0001, 1'b1}, '{1'b0, 32'h0000_0000, 1'b1}};
        run_list("backpressure", l);
    endtask

    task automatic test_idle();
        stim_t l[$];
        l = '{'{1'b1, 32'h0000_0002, 1'b1}, '{1'b0, 32'hFFFF_0000, 1'b1},
              '{1'b0, 32'h0000_0008, 1'b0}, '{1'b0, 32'h0000_0000, 1'b1}};
        run_list("idle", l);
    endtask

    task automatic test_back_to_back();
        stim_t l[$];
        stim_t s;
        for (int k = 0; k < 80; k++) begin
            s.v    = ($urandom_range(0, 3) != 0);
            s.ordy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: s.vec = 32'd1 << $urandom_range(0, 31);
                1: s.vec = 32'd0;
                default: s.vec = $urandom();
            endcase
            l.push_back(s);
        end
        run_list("b2b", l);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({s_valid, s_code, s_err, s_ready, p_valid, p_code, p_err, p_ready} !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got s=%b/%0d/%b/%b p=%b/%0d/%b/%b want 0/0/0/1", s_valid, s_code, s_err, s_ready, p_valid, p_code, p_err, p_ready);
        end
        n_cmp++;
        if ({s_cnt, p_cnt} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_cnt: got %0d/%0d want 0/0", s_cnt, p_cnt);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

`ifdef ONEHOT_ENCODER_ERRCNT_EN
    task automatic test_errcnt();
        logic [31:0] vecs [5] = '{32'h30, 32'h0, 32'h40, 32'h0, 32'h5};
        bit          clrs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            step(1'b1, vecs[k], 1'b1, 1'b0, clrs[k]);
            n_cmp++;
            if (s_cnt !== cnt_s || p_cnt !== cnt_p) begin
                n_fail++;
                $display("FAIL errcnt[%0d]: got %0d/%0d want %0d/%0d", k, s_cnt, p_cnt, cnt_s, cnt_p);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_codes();
        test_backpressure();
        test_idle();
        test_back_to_back();
        test_reset_mid();
`ifdef ONEHOT_ENCODER_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_pipe.md
ONEHOT_ENCODER_PIPE -- requirements
Module: onehot_encoder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input vector width, legal range 2..64.
REQ-002 SHALL have parameter OUT_W, default 5: code width, constrained 2^OUT_W >= WIDTH.
REQ-003 SHALL have parameter PRIORITY, default 0: 0 = strict one-hot mode, 1 = lowest-index priority mode.
REQ-004 SHALL have parameter INVALID_CODE, default all ones: code emitted for an invalid input.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  in_vec holds a request.
REQ-008 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-009 SHALL have port in_vec  input  WIDTH  vector to encode.
REQ-010 SHALL have port out_valid  output  1  out_code and out_err are valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port out_code  output  OUT_W  encoded bit index, or INVALID_CODE.
REQ-013 SHALL have port out_err  output  1  accepted input was invalid for the current mode.

Function
REQ-014 SHALL accept a request on any clock edge where in_valid=1 and in_ready=1.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-016 SHALL register an accepted result, giving out_valid=1 one cycle after acceptance (latency 1).
REQ-017 SHALL hold out_code and out_err stable while out_valid=1 and out_ready=0.
REQ-018 SHALL clear out_valid after a cycle with out_ready=1 and no new acceptance.
REQ-019 SHALL load the new result with no bubble when acceptance and consumption coincide (throughput 1/cycle).
REQ-020 SHALL, in strict mode, output index i with out_err=0 when exactly bit i is set.
REQ-021 SHALL, in strict mode, output INVALID_CODE with out_err=1 when zero or multiple bits are set.
REQ-022 SHALL, in priority mode, output the lowest set-bit index with out_err=0 when one or more bits are set.
REQ-023 SHALL, in priority mode, output INVALID_CODE with out_err=1 when in_vec is zero.
REQ-024 SHALL zero-extend the index to OUT_W bits, with bit 0 mapping to code 0 and no index remapping.
REQ-025 SHALL use out_err, not out_code, to tell index 2^OUT_W-1 apart from INVALID_CODE.
REQ-026 SHALL ignore in_vec when in_valid=0 and SHALL not change state on it.

Reset
REQ-027 SHALL, on a reset-high edge, set out_valid=0, out_code=0, out_err=0 and the error count to 0.
REQ-028 SHALL discard any held result on reset mid-operation; no acceptance on that edge.
REQ-029 SHALL drive in_ready=1 from the first edge after reset is released.

Configuration
REQ-030 SHALL add error counting when macro ONEHOT_ENCODER_ERRCNT_EN is defined, with ports err_clr (input, 1) and err_count (output, 16).
REQ-031 SHALL, with the macro, increment err_count on each accepted request with out_err=1, saturating at 0xFFFF.
REQ-032 SHALL, with the macro, make err_clr=1 set err_count to 0 on the next edge; clear wins over a simultaneous increment.
REQ-033 SHALL, without the macro, omit err_clr, err_count and the counter logic; all other behaviour unchanged.

Verification
REQ-034 Strict, WIDTH=32: in_vec=0x00000010 accepted with out_ready=1 -> next cycle out_valid=1, out_code=4, out_err=0.
REQ-035 Strict: in_vec=0x00000030, then 0x00000000 -> out_code=31, out_err=1 both times; err_count=2 when macro defined.
REQ-036 Backpressure: out_ready=0 for 3 cycles after accepting 0x80000000 -> in_ready=0, out_code=31, out_err=0 held; released with a new request 0x00000001 -> out_code=0 next cycle, no bubble.
REQ-037 Priority mode: in_vec=0x00F00000 -> out_code=20, out_err=0; in_vec=0 -> out_code=31, out_err=1.
REQ-038 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_code=0, in_ready=1; err_clr and an error acceptance on the same edge -> err_count=0.
